// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends a request-to-send, then shifts
// one command byte out on device clock edges and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       PS2_CLK_in,
  input  logic       PS2_DAT_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + INHIBIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_DAT  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_SHIFT     = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       frame_q, frame_d;
  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             clk_prev_q, fall_q;
  logic             clk_drive_q, clk_drive_d;
  logic             dat_drive_q, dat_drive_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             clk_s, dat_s, timeout_s;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign timeout_s = (cnt_q == TO_LAST);

  assign ps2_clk_drive_low = clk_drive_q;
  assign ps2_dat_drive_low = dat_drive_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  // Pin synchronizers and registered falling-edge detector on the device clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK_in};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT_in};
      clk_prev_q <= clk_s;
      fall_q     <= clk_prev_q & ~clk_s;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      frame_q     <= 10'd0;
      clk_drive_q <= 1'b0;
      dat_drive_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      clk_drive_q <= clk_drive_d;
      dat_drive_q <= dat_drive_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    clk_drive_d = 1'b0;
    dat_drive_d = dat_drive_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        dat_drive_d = 1'b0;
        if (send) begin
          frame_d     = {1'b1, odd_parity(tx_data), tx_data};
          busy_d      = 1'b1;
          clk_drive_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_INHIBIT;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          // Start bit is already on the bus; releasing the clock is the request-to-send
          dat_drive_d = 1'b1;
          cnt_d       = '0;
          bit_d       = 4'd0;
          state_d     = S_SHIFT;
        end else begin
          clk_drive_d = 1'b1;
          dat_drive_d = (cnt_q == INH_DAT);
          cnt_d       = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_s) begin
          dat_drive_d = 1'b0;
          busy_d      = 1'b0;
          error_d     = 1'b1;
          state_d     = S_IDLE;
        end else if (fall_q) begin
          dat_drive_d = ~frame_q[0];
          frame_d     = {1'b0, frame_q[9:1]};
          bit_d       = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = S_ACK;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ACK: begin
        dat_drive_d = 1'b0;
        cnt_d       = cnt_q + 1'b1;
        if (timeout_s) begin
          busy_d  = 1'b0;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (fall_q) begin
          if (dat_s) begin
            busy_d  = 1'b0;
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end else begin
          state_d = S_ACK;
        end
      end
      S_WAIT_IDLE: begin
        dat_drive_d = 1'b0;
        cnt_d       = cnt_q + 1'b1;
        if (timeout_s) begin
          busy_d  = 1'b0;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (clk_s && dat_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: begin
        dat_drive_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a behavioural keyboard clocking model.
module tb_ps2_host_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [7:0]  tx_data;
  logic        ps2_clk_drive_low, ps2_dat_drive_low;
  logic        busy, done, error;
  logic        dev_clk_low, dev_dat_low;
  wire         ps2_clk_pin = ~(ps2_clk_drive_low | dev_clk_low);
  wire         ps2_dat_pin = ~(ps2_dat_drive_low | dev_dat_low);

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0, err_cnt = 0, err_cyc = 0, busy_bad = 0, both_cnt = 0;
  int          rel_cyc = 0;
  int          d0, e0, n;
  logic [10:0] bits;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .rst(rst), .send(send), .tx_data(tx_data),
    .PS2_CLK_in(ps2_clk_pin), .PS2_DAT_in(ps2_dat_pin),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_dat_drive_low(ps2_dat_drive_low),
    .busy(busy), .done(done), .error(error)
  );

  // Pulse monitor: sees the values held during the cycle that just ended
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if ((done || error) && busy) busy_bad <= busy_bad + 1;
    if (done && error) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_send(input logic [7:0] d, input logic hold);
    @(negedge clk);
    send = 1'b1;
    tx_data = d;
    @(negedge clk);
    if (!hold) send = 1'b0;
  endtask

  // Measures the inhibit window starting at the first negedge with the clock driven low
  task automatic inhibit_check(input string tag);
    int cnt = 0;
    int first = -1;
    while (ps2_clk_drive_low && cnt < 100) begin
      if (ps2_dat_drive_low && first < 0) first = cnt;
      cnt++;
      @(negedge clk);
    end
    rel_cyc = cyc;
    chk({tag, "_inh_len"}, 32'(cnt), 32'd20);
    chk({tag, "_dat_first"}, 32'(first), 32'd19);
  endtask

  // Keyboard model: samples on rising edges (first one is the host clock release)
  task automatic dev_frame(input int phases, input logic ack_low, output logic [10:0] smp);
    smp = 11'd0;
    smp[0] = ps2_dat_pin;
    for (int k = 1; k <= phases && k <= 10; k++) begin
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      smp[k] = ps2_dat_pin;
      dev_clk_low = 1'b0;
    end
    if (phases > 10) begin
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b1;
      dev_dat_low = ack_low;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_events(input int lim);
    int k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    send = 1'b0;
    tx_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
    chk("rst_dat_drive", 32'(ps2_dat_drive_low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    // Reset in the middle of the inhibit window
    start_send(8'hED, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_inh_clk", 32'(ps2_clk_drive_low), 32'd1);
    chk("mid_inh_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    #2 rst = 1'b1;
    #1;
    chk("async_clk_rel", 32'(ps2_clk_drive_low), 32'd0);
    chk("async_dat_rel", 32'(ps2_dat_drive_low), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_err", 32'(err_cnt - e0), 32'd0);
    chk("abort_idle_clk", 32'(ps2_clk_drive_low), 32'd0);

    // 0xED set-LEDs: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
    d0 = done_cnt;
    e0 = err_cnt;
    start_send(8'hED, 1'b0);
    inhibit_check("ed");
    dev_frame(11, 1'b1, bits);
    chk("ed_bits", 32'(bits), 32'(11'b11_11101101_0));
    wait_events(300);
    chk("ed_done", 32'(done_cnt - d0), 32'd1);
    chk("ed_err", 32'(err_cnt - e0), 32'd0);
    chk("ed_busy", 32'(busy), 32'd0);

    // 0xF4 enable: data 0,0,1,0,1,1,1,1, parity 0
    d0 = done_cnt;
    e0 = err_cnt;
    start_send(8'hF4, 1'b0);
    inhibit_check("f4");
    dev_frame(11, 1'b1, bits);
    chk("f4_bits", 32'(bits), 32'(11'b10_11110100_0));
    wait_events(300);
    chk("f4_done", 32'(done_cnt - d0), 32'd1);
    chk("f4_err", 32'(err_cnt - e0), 32'd0);

    // NACK: device leaves data high during the ACK clock
    d0 = done_cnt;
    e0 = err_cnt;
    start_send(8'h55, 1'b0);
    inhibit_check("nack");
    dev_frame(11, 1'b0, bits);
    chk("nack_bits", 32'(bits), 32'(11'b11_01010101_0));
    wait_events(300);
    chk("nack_err", 32'(err_cnt - e0), 32'd1);
    chk("nack_no_done", 32'(done_cnt - d0), 32'd0);
    chk("nack_busy", 32'(busy), 32'd0);

    // Timeout: device stops after four clocks; send right after NACK is accepted
    d0 = done_cnt;
    e0 = err_cnt;
    start_send(8'hA0, 1'b0);
    inhibit_check("to");
    dev_frame(4, 1'b0, bits);
    wait_events(3000);
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_no_done", 32'(done_cnt - d0), 32'd0);
    chk("to_latency", 32'(err_cyc - rel_cyc), 32'd2000);
    chk("to_clk_rel", 32'(ps2_clk_drive_low), 32'd0);
    chk("to_dat_rel", 32'(ps2_dat_drive_low), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);

    // send held high: one frame per acceptance, next starts the cycle after done
    d0 = done_cnt;
    e0 = err_cnt;
    start_send(8'hF4, 1'b1);
    inhibit_check("hold1");
    dev_frame(11, 1'b1, bits);
    chk("hold1_bits", 32'(bits), 32'(11'b10_11110100_0));
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold1_done_seen", 32'(done), 32'd1);
    chk("hold1_busy_fall", 32'(busy), 32'd0);
    @(negedge clk);
    chk("hold_restart", 32'(ps2_clk_drive_low), 32'd1);
    send = 1'b0;
    inhibit_check("hold2");
    dev_frame(11, 1'b1, bits);
    chk("hold2_bits", 32'(bits), 32'(11'b10_11110100_0));
    wait_events(300);
    repeat (50) @(negedge clk);
    chk("hold_done_cnt", 32'(done_cnt - d0), 32'd2);
    chk("hold_err_cnt", 32'(err_cnt - e0), 32'd0);
    chk("hold_idle_clk", 32'(ps2_clk_drive_low), 32'd0);
    chk("hold_idle_busy", 32'(busy), 32'd0);

    chk("busy_with_pulse", 32'(busy_bad), 32'd0);
    chk("done_and_error", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
